// File: rtl/sp_ram_param.sv
// Parametrised single-port synchronous RAM with per-byte write enables,
// selectable read latency (1 or 2) and a post-reset zero-fill sequencer.
module sp_ram_param #(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 2,
    parameter int RD_LAT       = 1,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic                  rd,
    input  logic [ADDR_W-1:0]     add,
    input  logic [DATA_W-1:0]     din,
    input  logic [DATA_W/8-1:0]   be,
    output logic [DATA_W-1:0]     dout,
    output logic                  dout_vld,
    output logic                  busy,
    output logic                  err
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] CNT_ONE  = ADDR_W'(1);
    localparam logic              CLR_EN   = (CLEAR_ON_RST != 0);

    // Widen the byte enables into a bit mask over the data word.
    function automatic logic [DATA_W-1:0] expand_be(input logic [NB-1:0] b);
        logic [DATA_W-1:0] m;
        m = {DATA_W{1'b0}};
        for (int i = 0; i < NB; i++) begin
            m[8*i +: 8] = {8{b[i]}};
        end
        return m;
    endfunction

    logic [DATA_W-1:0] mem_r [DEPTH];

    logic [0:0]        state_r;
    logic [ADDR_W-1:0] clr_cnt_r;
    logic              busy_r;
    logic              err_r;
    logic [DATA_W-1:0] rd_data_r;
    logic              rd_vld_r;

    logic              ready_s;
    logic              rd_acc_s;
    logic              we_s;
    logic [ADDR_W-1:0] wa_s;
    logic [DATA_W-1:0] wd_s;
    logic [DATA_W-1:0] wm_s;

    assign ready_s  = (state_r == ST_READY) && !rst;
    assign rd_acc_s = ready_s && rd && !wr;

    // Select the single write port source: clear sequencer or user write.
    always_comb begin
        we_s = 1'b0;
        wa_s = {ADDR_W{1'b0}};
        wd_s = {DATA_W{1'b0}};
        wm_s = {DATA_W{1'b0}};
        if ((state_r == ST_CLEAR) && !rst) begin
            we_s = 1'b1;
            wa_s = clr_cnt_r;
            wd_s = {DATA_W{1'b0}};
            wm_s = {DATA_W{1'b1}};
        end else if (ready_s && wr) begin
            we_s = 1'b1;
            wa_s = add;
            wd_s = din;
            wm_s = expand_be(be);
        end else begin
            we_s = 1'b0;
        end
    end

    // Storage array; no reset so contents survive when clearing is disabled.
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem_r[wa_s] <= (mem_r[wa_s] & ~wm_s) | (wd_s & wm_s);
        end
    end

    // Clear sequencer: one word per cycle, READY leaves at the last write edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= CLR_EN ? ST_CLEAR : ST_READY;
            clr_cnt_r <= {ADDR_W{1'b0}};
            busy_r    <= CLR_EN;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    clr_cnt_r <= clr_cnt_r + CNT_ONE;
                    if (clr_cnt_r == CNT_LAST) begin
                        state_r <= ST_READY;
                        busy_r  <= 1'b0;
                    end
                end
                ST_READY: begin
                    state_r <= ST_READY;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_READY;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // First read stage and the illegal-request flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_r <= {DATA_W{1'b0}};
            rd_vld_r  <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            rd_vld_r <= rd_acc_s;
            err_r    <= ready_s && wr && rd;
            if (rd_acc_s) begin
                rd_data_r <= mem_r[add];
            end
        end
    end

    // Any RD_LAT other than 2 behaves as latency 1.
    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] out_data_r;
            logic              out_vld_r;

            // Output register stage, holds data between reads.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_data_r <= {DATA_W{1'b0}};
                    out_vld_r  <= 1'b0;
                end else begin
                    out_vld_r <= rd_vld_r;
                    if (rd_vld_r) begin
                        out_data_r <= rd_data_r;
                    end
                end
            end

            assign dout     = out_data_r;
            assign dout_vld = out_vld_r;
        end else begin : g_lat1
            assign dout     = rd_data_r;
            assign dout_vld = rd_vld_r;
        end
    endgenerate

    assign busy = busy_r;
    assign err  = err_r;

endmodule

// File: tb/tb_sp_ram_param.sv
// Scoreboard bench for sp_ram_param: RD_LAT=1 and RD_LAT=2 instances share stimulus.
module tb_sp_ram_param;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr;
    logic        rd;
    logic [1:0]  add;
    logic [15:0] din;
    logic [1:0]  be;

    logic [15:0] dout1, dout2;
    logic        vld1, vld2, busy1, busy2, err1, err2;

    exp_t        q1[$];
    exp_t        q2[$];
    logic [15:0] model_mem [4];
    logic [15:0] model_dout1;
    logic [15:0] model_dout2;
    int          cyc     = 0;
    int          err_cyc = -1;
    int          errors  = 0;
    int          checks  = 0;

    sp_ram_param #(.DATA_W(16), .ADDR_W(2), .RD_LAT(1), .CLEAR_ON_RST(1)) dut1 (
        .clk(clk), .rst(rst), .wr(wr), .rd(rd), .add(add), .din(din), .be(be),
        .dout(dout1), .dout_vld(vld1), .busy(busy1), .err(err1)
    );

    sp_ram_param #(.DATA_W(16), .ADDR_W(2), .RD_LAT(2), .CLEAR_ON_RST(1)) dut2 (
        .clk(clk), .rst(rst), .wr(wr), .rd(rd), .add(add), .din(din), .be(be),
        .dout(dout2), .dout_vld(vld2), .busy(busy2), .err(err2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output monitor: pops the scoreboard on every valid and checks hold otherwise.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (vld1) begin
            if (q1.size() == 0) begin
                check("vld1_unexpected", 32'(vld1), 32'd0);
            end else begin
                e = q1.pop_front();
                check("dout1", 32'(dout1), 32'(e.data));
                check("lat1", cyc, e.cyc);
                model_dout1 = e.data;
            end
        end else begin
            check("hold1", 32'(dout1), 32'(model_dout1));
        end
        if (vld2) begin
            if (q2.size() == 0) begin
                check("vld2_unexpected", 32'(vld2), 32'd0);
            end else begin
                e = q2.pop_front();
                check("dout2", 32'(dout2), 32'(e.data));
                check("lat2", cyc, e.cyc);
                model_dout2 = e.data;
            end
        end else begin
            check("hold2", 32'(dout2), 32'(model_dout2));
        end
        check("err1", 32'(err1), 32'(cyc == err_cyc));
        check("err2", 32'(err2), 32'(cyc == err_cyc));
    end

    task automatic model_write(input logic [1:0] a, input logic [15:0] d, input logic [1:0] b);
        if (b[0]) model_mem[a][7:0]  = d[7:0];
        if (b[1]) model_mem[a][15:8] = d[15:8];
    endtask

    task automatic do_write(input logic [1:0] a, input logic [15:0] d, input logic [1:0] b);
        wr = 1'b1; rd = 1'b0; add = a; din = d; be = b;
        model_write(a, d, b);
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic do_read(input logic [1:0] a);
        exp_t e;
        wr = 1'b0; rd = 1'b1; add = a;
        e.data = model_mem[a];
        e.cyc  = cyc + 1;
        q1.push_back(e);
        e.cyc  = cyc + 2;
        q2.push_back(e);
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic do_wr_rd(input logic [1:0] a, input logic [15:0] d, input logic [1:0] b);
        wr = 1'b1; rd = 1'b1; add = a; din = d; be = b;
        model_write(a, d, b);
        err_cyc = cyc + 1;
        @(negedge clk);
        wr = 1'b0; rd = 1'b0;
    endtask

    task automatic idle(input int n);
        wr = 1'b0; rd = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; wr = 1'b0; rd = 1'b0;
        q1.delete();
        q2.delete();
        model_dout1 = 16'h0000;
        model_dout2 = 16'h0000;
        err_cyc = -1;
        for (int i = 0; i < 4; i++) model_mem[i] = 16'h0000;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Counts busy cycles after release; optionally pokes wr then rd while busy.
    task automatic count_busy(input bit poke);
        int n;
        n = 0;
        check("busy1_at_release", 32'(busy1), 32'd1);
        check("busy2_at_release", 32'(busy2), 32'd1);
        while (busy1 && n < 20) begin
            wr = 1'b0; rd = 1'b0;
            if (poke && n == 0) begin
                wr = 1'b1; add = 2'd0; din = 16'h5555; be = 2'b11;
            end else if (poke && n == 1) begin
                rd = 1'b1; add = 2'd0;
            end
            @(negedge clk);
            n++;
        end
        wr = 1'b0; rd = 1'b0;
        check("busy_cycles", n, 32'd4);
        check("busy2_done", 32'(busy2), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; wr = 1'b0; rd = 1'b0; add = 2'd0; din = 16'h0000; be = 2'b00;
        model_dout1 = 16'h0000;
        model_dout2 = 16'h0000;
        for (int i = 0; i < 4; i++) model_mem[i] = 16'h0000;
        repeat (2) @(negedge clk);
        check("dout1_reset", 32'(dout1), 32'd0);
        check("vld1_reset", 32'(vld1), 32'd0);
        check("busy1_reset", 32'(busy1), 32'd1);
        check("err1_reset", 32'(err1), 32'd0);
        rst = 1'b0;

        // Post-reset clear, then read every word back as zero
        count_busy(1'b0);
        for (int a = 0; a < 4; a++) do_read(2'(a));
        idle(3);

        // Full-word writes, then back-to-back reads
        do_write(2'd1, 16'ha00f, 2'b11);
        do_write(2'd2, 16'hffff, 2'b11);
        do_write(2'd3, 16'h000f, 2'b11);
        do_write(2'd0, 16'h4321, 2'b11);
        do_read(2'd1);
        do_read(2'd2);
        do_read(2'd3);
        idle(3);

        // Byte-enable merge and read-after-write; be=0 is a no-op
        do_write(2'd2, 16'hffff, 2'b11);
        do_write(2'd2, 16'h1234, 2'b01);
        do_read(2'd2);
        idle(3);
        do_write(2'd2, 16'h0000, 2'b00);
        do_read(2'd2);
        idle(3);

        // Simultaneous wr and rd: write lands, read dropped, err pulses
        do_wr_rd(2'd3, 16'hbeef, 2'b11);
        idle(2);
        do_read(2'd3);
        idle(3);

        // Isolated read for latency/hold observation on both instances
        do_read(2'd1);
        idle(4);

        // In-flight read discarded by reset, then reset again mid-clear
        do_read(2'd1);
        do_reset();
        @(negedge clk);
        do_reset();
        count_busy(1'b1);
        do_read(2'd0);
        idle(4);

        check("q1_drained", q1.size(), 32'd0);
        check("q2_drained", q2.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
